// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state type, default width and counter sizing for serial_add_ctrl.
package serial_add_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEFAULT_WIDTH = 8;
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction
endpackage

// File: rtl/fullAdder.sv
// fullAdder: single-bit full adder cell, time-shared by serial_add_ctrl.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit adder, LSB first, one bit per clock through one fullAdder.
// Define SERIAL_ADD_SUB_EN to add a 'sub' port that turns the operation into a - b.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = cnt_width(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, b_ld;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic             c_ld, s, co, last, accept, run;
`ifdef SERIAL_ADD_SUB_EN
  // Subtraction is a + ~b + 1, so cin is ignored when sub is set.
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub | cin;
`else
  assign b_ld = b;
  assign c_ld = cin;
`endif
  fullAdder u_fa (
    .a   (a_q[0]),
    .b   (b_q[0]),
    .cin (carry_q),
    .sum (s),
    .cout(co)
  );
  assign last   = cnt_q == CW'(WIDTH - 1);
  assign accept = (state_q == IDLE) && start;
  assign run    = state_q == RUN;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (start ? RUN : IDLE) :
              (state_q == RUN)  ? (last ? DONE : RUN)  : IDLE;
  end
  always_comb begin
    busy = state_q == RUN;
    done = state_q == DONE;
  end
  always_comb begin
    a_d     = accept ? a    : run ? a_q >> 1 : a_q;
    b_d     = accept ? b_ld : run ? b_q >> 1 : b_q;
    carry_d = accept ? c_ld : run ? co       : carry_q;
    cnt_d   = accept ? '0   : run ? cnt_q + 1'b1 : cnt_q;
    sum_d   = run ? {s, sum_q[WIDTH-1:1]} : sum_q;
    cout_d  = (run && last) ? co : cout_q;
    ovf_d   = (run && last) ? carry_q ^ co : ovf_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed checks of serial_add_ctrl at WIDTH=8 plus an exhaustive WIDTH=3 sweep.
module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, cin = 1'b0, busy, done, cout, ovf;
  logic [7:0] a = '0, b = '0, sum;
  logic       start3 = 1'b0, cin3 = 1'b0, busy3, done3, cout3, ovf3;
  logic [2:0] a3 = '0, b3 = '0, sum3;
`ifdef SERIAL_ADD_SUB_EN
  logic       sub = 1'b0, sub3 = 1'b0;
`endif
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_add_ctrl #(.WIDTH(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub3),
`endif
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .ovf(ovf3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                     input bit scramble, input logic [7:0] es, input logic ec, input logic eo);
    int n, bc;
    logic [7:0] prev;
    @(negedge clk);
    prev = sum;
    start = 1'b1; a = ta; b = tb_; cin = tc;
    @(negedge clk);
    n = 1; bc = 0;
    chk({tag, ":hold"}, sum, prev);
    start = 1'b0;
    while (!done && n < 20) begin
      bc += int'(busy);
      if (scramble) begin
        start = n[0]; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, ":lat"}, n, 9);
    chk({tag, ":busycyc"}, bc, 8);
    chk({tag, ":busy_at_done"}, busy, 0);
    chk({tag, ":sum"}, sum, es);
    chk({tag, ":cout"}, cout, ec);
    chk({tag, ":ovf"}, ovf, eo);
  endtask

  task automatic op3(input logic [2:0] ta, input logic [2:0] tb_, input logic tc);
    int n, s, sa, sb, ss;
    logic ov;
    @(negedge clk);
    start3 = 1'b1; a3 = ta; b3 = tb_; cin3 = tc;
    @(negedge clk);
    start3 = 1'b0;
    n = 1;
    while (!done3 && n < 12) begin
      @(negedge clk);
      n++;
    end
    s  = int'(ta) + int'(tb_) + int'(tc);
    sa = ta[2] ? int'(ta) - 8 : int'(ta);
    sb = tb_[2] ? int'(tb_) - 8 : int'(tb_);
    ss = sa + sb + int'(tc);
    ov = (ss > 3) || (ss < -4);
    chk($sformatf("w3_lat a=%0d b=%0d c=%0d", ta, tb_, tc), n, 4);
    chk($sformatf("w3 a=%0d b=%0d c=%0d", ta, tb_, tc), {ovf3, cout3, sum3}, {ov, s[3:0]});
  endtask

  initial begin
    int last_i, pulses;
    bit seen;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout_ovf", {cout, ovf}, 0);
    chk("rst_w3", {busy3, done3, sum3, cout3, ovf3}, 0);
    reset_n = 1'b1;

    op8("add5A33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1);
    op8("addFF01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("add7F00c", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("scramble", 8'h12, 8'h34, 1'b0, 1'b1, 8'h46, 1'b0, 1'b0);

    // Held start: a new operation every WIDTH+2 cycles.
    @(negedge clk);
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    last_i = 0; pulses = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done) begin
        chk($sformatf("held_sum%0d", pulses), sum, 8'h46);
        if (pulses > 0) chk($sformatf("held_gap%0d", pulses), i - last_i, 10);
        last_i = i;
        pulses++;
      end
    end
    start = 1'b0;
    chk("held_pulses", pulses, 3);

    // Reset mid-RUN at RUN cycle 4.
    @(negedge clk);
    start = 1'b1; a = 8'h5A; b = 8'h33; cin = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_sum", sum, 0);
    chk("arst_cout_ovf", {cout, ovf}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      seen |= done | busy;
    end
    chk("arst_nodone", seen, 0);
    op8("post_rst", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    op8("sub1020", 8'h10, 8'h20, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0);
    op8("sub8001", 8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b1);
    sub = 1'b0;
`endif

    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        for (int c = 0; c < 2; c++)
          op3(3'(x), 3'(y), 1'(c));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Bit-serial adder sequencer that time-shares one 1-bit fullAdder cell to add two WIDTH-bit operands, LSB first, one bit per clock. It owns the operand shift registers, the carry flop, the bit counter and a start/done handshake. It sits between switch/key input logic and the LEDR/HEX display logic on the DE1_SoC top level, replacing a WIDTH-wide ripple adder.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
clk  input  1  system clock (CLOCK_50 at top level)
reset_n  input  1  asynchronous, active-low reset
start  input  1  request a new addition; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepted start edge
b  input  WIDTH  operand B; captured on the accepted start edge
cin  input  1  carry-in; captured on the accepted start edge
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; sum/cout/ovf valid from this cycle
sum  output  WIDTH  result; holds until the next accepted start
cout  output  1  unsigned carry-out of the MSB
ovf  output  1  signed overflow, (carry into MSB) XOR cout

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; counter and shift registers cleared. Reset asserted mid-RUN aborts the operation with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. When start=1 at a clock edge, load A_sh<=a, B_sh<=b, carry<=cin, cnt<=0, and go to RUN. sum/cout/ovf keep their previous values until the first RUN edge.
- RUN (exactly WIDTH cycles): the fullAdder inputs are A_sh[0], B_sh[0] and carry. On each edge:
  - sum <= {s, sum[WIDTH-1:1]}, shifting in from the MSB;
  - A_sh and B_sh shift right by one;
  - carry <= co; cnt <= cnt+1.
  - When cnt==WIDTH-1, the carry input is also latched as the into-MSB carry, cout<=co, ovf<=carry XOR co, and the next state is DONE.
- DONE (1 cycle): done=1, busy=0, then unconditional return to IDLE.
- start is ignored in RUN and in DONE. If start is held high continuously, a new operation is accepted in the IDLE cycle following DONE, giving WIDTH+2 cycles per operation.
- Latency: done is high on the cycle beginning WIDTH+1 edges after the start-accept edge. busy is high for exactly WIDTH cycles.
- Operand inputs are don't-care outside the accept edge. Changing them during RUN must not affect the result.
- Counter width is $clog2(WIDTH)+1; no wrap occurs inside an operation.

Optional Feature:
Macro SERIAL_ADD_SUB_EN.
- Defined: adds input port sub (1 bit), captured with the operands. When sub=1, B_sh is loaded with ~b and carry with 1, ignoring cin, so sum = a - b. In this mode cout=1 means no borrow, and ovf is the signed subtraction overflow.
- Undefined: no sub port; the block performs addition only.

Decomposition:
- Package serial_add_pkg holds:
  - the state enum typedef {IDLE, RUN, DONE};
  - localparam default WIDTH=8;
  - a function cnt_width(WIDTH).
- One sub-module: the existing fullAdder cell, instantiated once with ports a, b, cin, sum, cout. No other sub-modules.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, cin=0, start pulse -> busy high for 8 cycles, done pulse on the 9th cycle after accept; sum=0x8D, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- Hold start=1 for 30 cycles with fixed operands -> done pulses exactly 10 cycles apart. Toggling start and operands during RUN does not change sum.
- Pull reset_n low for 1 cycle at RUN cycle 4 -> all outputs 0 immediately, state IDLE, no done pulse. The next start computes correctly.
- WIDTH=3: exhaustive sweep over all a, b, cin (128 cases) checked against {cout,sum}=a+b+cin and ovf against the signed reference.
- With SERIAL_ADD_SUB_EN, sub=1, a=0x10, b=0x20 -> sum=0xF0, cout=0, ovf=0. With a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
